// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with dcache request control. Latency: 1 cycle on an enabled edge.
// Backpressure: mem_busy holds the entry and stalls upstream until dhit. Option: EX_MEM_TRACKER_EN.
module ex_mem_reg (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable_EX_MEM,
    input  logic        flush_EX_MEM,
    input  logic        dREN_ID_EX,
    input  logic        dWEN_ID_EX,
    input  logic        WEN_ID_EX,
    input  logic        halt_ID_EX,
    input  logic [1:0]  reg_src_ID_EX,
    input  logic [4:0]  wsel_EX,
    input  logic [31:0] port_o_EX,
    input  logic [31:0] rdat2_ID_EX,
    input  logic [31:0] next_imemaddr_ID_EX,
    input  logic        dhit,
    input  logic [31:0] dload,
`ifdef EX_MEM_TRACKER_EN
    input  logic [31:0] instruction_ID_EX,
    input  logic [31:0] imemaddr_ID_EX,
    output logic [31:0] instruction_EX_MEM,
    output logic [31:0] imemaddr_EX_MEM,
`endif
    output logic        dREN_EX_MEM,
    output logic        dWEN_EX_MEM,
    output logic        WEN_EX_MEM,
    output logic        halt_EX_MEM,
    output logic [1:0]  reg_src_EX_MEM,
    output logic [4:0]  wsel_EX_MEM,
    output logic [31:0] port_o_EX_MEM,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemstore_EX_MEM,
    output logic [31:0] next_imemaddr_EX_MEM,
    output logic [31:0] dload_EX_MEM,
    output logic        dmemREN,
    output logic        dmemWEN,
    output logic        mem_busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    typedef struct packed {
        logic        dren;
        logic        dwen;
        logic        wen;
        logic        halt;
        logic [1:0]  reg_src;
        logic [4:0]  wsel;
        logic [31:0] port_o;
        logic [31:0] store;
        logic [31:0] npc;
        logic [31:0] dload;
`ifdef EX_MEM_TRACKER_EN
        logic [31:0] instr;
        logic [31:0] iaddr;
`endif
    } entry_t;

    state_t r_state;
    state_t w_next_state;
    entry_t r_entry;
    entry_t w_loaded;
    entry_t w_flushed;
    logic   w_is_load;

    always_comb begin
        w_loaded         = '0;
        w_loaded.dren    = dREN_ID_EX;
        w_loaded.dwen    = dWEN_ID_EX;
        w_loaded.wen     = WEN_ID_EX;
        // halt accumulates across loads; only reset clears it
        w_loaded.halt    = r_entry.halt | halt_ID_EX;
        w_loaded.reg_src = reg_src_ID_EX;
        w_loaded.wsel    = wsel_EX;
        w_loaded.port_o  = port_o_EX;
        w_loaded.store   = rdat2_ID_EX;
        w_loaded.npc     = next_imemaddr_ID_EX;
`ifdef EX_MEM_TRACKER_EN
        w_loaded.instr   = instruction_ID_EX;
        w_loaded.iaddr   = imemaddr_ID_EX;
`endif
        w_flushed        = '0;
        w_flushed.halt   = r_entry.halt;
    end

    assign w_is_load = r_entry.dren & ~r_entry.dwen;

    always_comb begin
        w_next_state = r_state;
        if (r_state == ACCESS) begin
            if (dhit) w_next_state = DONE;
        end else if (flush_EX_MEM) begin
            w_next_state = IDLE;
        end else if (enable_EX_MEM) begin
            w_next_state = (dREN_ID_EX | dWEN_ID_EX) ? ACCESS : IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_entry <= '0;
        end else if (r_state == ACCESS) begin
            if (dhit && w_is_load) r_entry.dload <= dload;
        end else if (flush_EX_MEM) begin
            r_entry <= w_flushed;
        end else if (enable_EX_MEM) begin
            r_entry <= w_loaded;
        end
    end

    assign dREN_EX_MEM          = r_entry.dren;
    assign dWEN_EX_MEM          = r_entry.dwen;
    assign WEN_EX_MEM           = r_entry.wen;
    assign halt_EX_MEM          = r_entry.halt;
    assign reg_src_EX_MEM       = r_entry.reg_src;
    assign wsel_EX_MEM          = r_entry.wsel;
    assign port_o_EX_MEM        = r_entry.port_o;
    assign dmemaddr             = r_entry.port_o;
    assign dmemstore_EX_MEM     = r_entry.store;
    assign next_imemaddr_EX_MEM = r_entry.npc;
    assign dload_EX_MEM         = r_entry.dload;
`ifdef EX_MEM_TRACKER_EN
    assign instruction_EX_MEM   = r_entry.instr;
    assign imemaddr_EX_MEM      = r_entry.iaddr;
`endif

    // write wins when both control bits are set
    assign dmemWEN  = (r_state == ACCESS) & r_entry.dwen;
    assign dmemREN  = (r_state == ACCESS) & r_entry.dren & ~r_entry.dwen;
    assign mem_busy = (r_state == ACCESS);

endmodule

// File: tb/tb_ex_mem_reg.sv
// Randomized and directed bench for ex_mem_reg against a behavioural entry model.
module tb_ex_mem_reg;

    logic        CLK = 1'b0;
    logic        RST, enable_EX_MEM, flush_EX_MEM;
    logic        dREN_ID_EX, dWEN_ID_EX, WEN_ID_EX, halt_ID_EX;
    logic [1:0]  reg_src_ID_EX;
    logic [4:0]  wsel_EX;
    logic [31:0] port_o_EX, rdat2_ID_EX, next_imemaddr_ID_EX;
    logic        dhit;
    logic [31:0] dload;
    logic        dREN_EX_MEM, dWEN_EX_MEM, WEN_EX_MEM, halt_EX_MEM;
    logic [1:0]  reg_src_EX_MEM;
    logic [4:0]  wsel_EX_MEM;
    logic [31:0] port_o_EX_MEM, dmemaddr, dmemstore_EX_MEM, next_imemaddr_EX_MEM, dload_EX_MEM;
    logic        dmemREN, dmemWEN, mem_busy;

    int compared = 0;
    int mismatched = 0;

    // model: the held entry plus whether a dcache access is still outstanding
    logic        m_dren, m_dwen, m_wen, m_halt, m_pending;
    logic [1:0]  m_src;
    logic [4:0]  m_wsel;
    logic [31:0] m_addr, m_store, m_npc, m_dload;

    ex_mem_reg dut (
        .CLK(CLK), .RST(RST), .enable_EX_MEM(enable_EX_MEM), .flush_EX_MEM(flush_EX_MEM),
        .dREN_ID_EX(dREN_ID_EX), .dWEN_ID_EX(dWEN_ID_EX), .WEN_ID_EX(WEN_ID_EX),
        .halt_ID_EX(halt_ID_EX), .reg_src_ID_EX(reg_src_ID_EX), .wsel_EX(wsel_EX),
        .port_o_EX(port_o_EX), .rdat2_ID_EX(rdat2_ID_EX),
        .next_imemaddr_ID_EX(next_imemaddr_ID_EX), .dhit(dhit), .dload(dload),
        .dREN_EX_MEM(dREN_EX_MEM), .dWEN_EX_MEM(dWEN_EX_MEM), .WEN_EX_MEM(WEN_EX_MEM),
        .halt_EX_MEM(halt_EX_MEM), .reg_src_EX_MEM(reg_src_EX_MEM),
        .wsel_EX_MEM(wsel_EX_MEM), .port_o_EX_MEM(port_o_EX_MEM), .dmemaddr(dmemaddr),
        .dmemstore_EX_MEM(dmemstore_EX_MEM), .next_imemaddr_EX_MEM(next_imemaddr_EX_MEM),
        .dload_EX_MEM(dload_EX_MEM), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
        .mem_busy(mem_busy)
    );

    initial forever #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        if (RST) begin
            {m_dren, m_dwen, m_wen, m_halt, m_pending} = '0;
            m_src = '0; m_wsel = '0;
            m_addr = '0; m_store = '0; m_npc = '0; m_dload = '0;
        end else if (m_pending) begin
            if (dhit) begin
                m_pending = 1'b0;
                if (m_dren && !m_dwen) m_dload = dload;
            end
        end else if (flush_EX_MEM) begin
            {m_dren, m_dwen, m_wen} = '0;
            m_src = '0; m_wsel = '0;
            m_addr = '0; m_store = '0; m_npc = '0; m_dload = '0;
        end else if (enable_EX_MEM) begin
            m_dren = dREN_ID_EX; m_dwen = dWEN_ID_EX; m_wen = WEN_ID_EX;
            m_halt = m_halt | halt_ID_EX;
            m_src = reg_src_ID_EX; m_wsel = wsel_EX;
            m_addr = port_o_EX; m_store = rdat2_ID_EX; m_npc = next_imemaddr_ID_EX;
            m_dload = '0;
            m_pending = dREN_ID_EX | dWEN_ID_EX;
        end
    endtask

    task automatic check_all();
        chk("dREN_EX_MEM", 32'(dREN_EX_MEM), 32'(m_dren));
        chk("dWEN_EX_MEM", 32'(dWEN_EX_MEM), 32'(m_dwen));
        chk("WEN_EX_MEM", 32'(WEN_EX_MEM), 32'(m_wen));
        chk("halt_EX_MEM", 32'(halt_EX_MEM), 32'(m_halt));
        chk("reg_src", 32'(reg_src_EX_MEM), 32'(m_src));
        chk("wsel", 32'(wsel_EX_MEM), 32'(m_wsel));
        chk("port_o", port_o_EX_MEM, m_addr);
        chk("dmemaddr", dmemaddr, m_addr);
        chk("dmemstore", dmemstore_EX_MEM, m_store);
        chk("next_imemaddr", next_imemaddr_EX_MEM, m_npc);
        chk("dload_EX_MEM", dload_EX_MEM, m_dload);
        chk("dmemWEN", 32'(dmemWEN), 32'(m_pending & m_dwen));
        chk("dmemREN", 32'(dmemREN), 32'(m_pending & m_dren & ~m_dwen));
        chk("mem_busy", 32'(mem_busy), 32'(m_pending));
    endtask

    task automatic step();
        @(posedge CLK);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic rand_data();
        dREN_ID_EX = 1'($urandom); dWEN_ID_EX = 1'($urandom);
        WEN_ID_EX = 1'($urandom); halt_ID_EX = 1'($urandom);
        reg_src_ID_EX = 2'($urandom); wsel_EX = 5'($urandom);
        port_o_EX = $urandom; rdat2_ID_EX = $urandom; next_imemaddr_ID_EX = $urandom;
        dload = $urandom;
    endtask

    task automatic quiet();
        RST = 0; enable_EX_MEM = 0; flush_EX_MEM = 0; dhit = 0;
    endtask

    int ren_cycles;

    initial begin
        rand_data();
        quiet();
        // reset with random inputs
        RST = 1; enable_EX_MEM = 1'($urandom); flush_EX_MEM = 1'($urandom); dhit = 1'($urandom);
        step();
        rand_data();
        step();
        chk("rst_busy", 32'(mem_busy), 32'd0);
        chk("rst_halt", 32'(halt_EX_MEM), 32'd0);
        chk("rst_dmemREN", 32'(dmemREN), 32'd0);

        // load with dhit three cycles after request starts
        quiet(); rand_data();
        dREN_ID_EX = 1; dWEN_ID_EX = 0; halt_ID_EX = 0; port_o_EX = 32'h100;
        enable_EX_MEM = 1;
        ren_cycles = 0;
        step(); ren_cycles += int'(dmemREN);
        chk("load_addr", dmemaddr, 32'h100);
        enable_EX_MEM = 0; rand_data();
        step(); ren_cycles += int'(dmemREN);
        chk("load_busy", 32'(mem_busy), 32'd1);
        step(); ren_cycles += int'(dmemREN);
        dhit = 1; dload = 32'hDEADBEEF;
        step(); ren_cycles += int'(dmemREN);
        dhit = 0;
        chk("load_ren_cycles", 32'(ren_cycles), 32'd3);
        chk("load_data", dload_EX_MEM, 32'hDEADBEEF);
        chk("load_busy_after", 32'(mem_busy), 32'd0);

        // store held against enable and flush
        quiet(); rand_data();
        dWEN_ID_EX = 1; rdat2_ID_EX = 32'h55; halt_ID_EX = 0; enable_EX_MEM = 1;
        step();
        rand_data(); enable_EX_MEM = 1; flush_EX_MEM = 1;
        step();
        flush_EX_MEM = 0;
        step();
        chk("store_hold_data", dmemstore_EX_MEM, 32'h55);
        chk("store_hold_wen", 32'(dmemWEN), 32'd1);
        enable_EX_MEM = 0; dhit = 1;
        step();
        dhit = 0;
        chk("store_done_wen", 32'(dmemWEN), 32'd0);

        // flush beats enable outside ACCESS
        quiet(); rand_data();
        WEN_ID_EX = 1; wsel_EX = 5'd5; halt_ID_EX = 0;
        enable_EX_MEM = 1; flush_EX_MEM = 1;
        step();
        chk("flush_wen", 32'(WEN_EX_MEM), 32'd0);
        chk("flush_wsel", 32'(wsel_EX_MEM), 32'd0);

        // sticky halt
        quiet(); rand_data();
        dREN_ID_EX = 0; dWEN_ID_EX = 0; halt_ID_EX = 1; enable_EX_MEM = 1;
        step();
        enable_EX_MEM = 0; flush_EX_MEM = 1;
        step();
        flush_EX_MEM = 0; enable_EX_MEM = 1; halt_ID_EX = 0; dREN_ID_EX = 0; dWEN_ID_EX = 0;
        step();
        chk("halt_sticky", 32'(halt_EX_MEM), 32'd1);
        quiet(); RST = 1;
        step();
        chk("halt_cleared", 32'(halt_EX_MEM), 32'd0);

        // reset in the middle of an access
        quiet(); rand_data();
        dREN_ID_EX = 1; enable_EX_MEM = 1;
        step();
        chk("mid_busy_pre", 32'(mem_busy), 32'd1);
        quiet(); RST = 1;
        step();
        chk("mid_ren", 32'(dmemREN), 32'd0);
        chk("mid_wen", 32'(dmemWEN), 32'd0);
        chk("mid_busy", 32'(mem_busy), 32'd0);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            rand_data();
            RST = ($urandom_range(0, 39) == 0);
            flush_EX_MEM = ($urandom_range(0, 5) == 0);
            enable_EX_MEM = 1'($urandom);
            dhit = ($urandom_range(0, 2) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
